// File: rtl/instruction_fetch_if.sv
// Fetch-unit bundle: instruction memory port, decoder handshake, redirect/halt controls.
// fetchCount is only present when FETCH_STATS_EN is defined.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]  memAddress;
    logic [INSTR_WIDTH-1:0] memData;
    logic [INSTR_WIDTH-1:0] instrOut;
    logic [ADDR_WIDTH-1:0]  instrPc;
    logic                   instrValid;
    logic                   instrReady;
    logic                   branchTaken;
    logic [ADDR_WIDTH-1:0]  branchTarget;
    logic                   haltReq;
`ifdef FETCH_STATS_EN
    logic [15:0]            fetchCount;
`endif

    modport master (
        output memAddress, instrOut, instrPc, instrValid,
`ifdef FETCH_STATS_EN
        output fetchCount,
`endif
        input  memData, instrReady, branchTaken, branchTarget, haltReq
    );

    modport slave (
        input  memAddress, instrOut, instrPc, instrValid,
`ifdef FETCH_STATS_EN
        input  fetchCount,
`endif
        output memData, instrReady, branchTaken, branchTarget, haltReq
    );
endinterface

// File: rtl/instruction_fetch.sv
// NanoRisc fetch unit with 2-entry prefetch buffer; optional push counter under FETCH_STATS_EN.
// Latency: address issued in cycle N is at the buffer head in cycle N+1; branch costs one bubble.
// Backpressure: instrReady low lets the buffer fill to 2, then the PC holds until a pop.
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_fetch_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  fetchPc;
    logic [1:0]             count;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic [INSTR_WIDTH-1:0] tail_instr;
    logic [ADDR_WIDTH-1:0]  tail_pc;

    logic pop;
    logic issue;
    logic redirect;
    logic push_to_head;

    assign bus.memAddress = fetchPc;
    assign bus.instrValid = (count != 2'd0);
    assign bus.instrOut   = head_instr;
    assign bus.instrPc    = head_pc;

    assign pop      = bus.instrValid & bus.instrReady;
    assign redirect = bus.branchTaken & (state != IDLE);
    assign issue    = (state == RUN) & ~bus.haltReq & ~bus.branchTaken
                    & ((count < 2'd2) | pop);
    // The new word lands at the head when the buffer is, or is about to become, empty.
    assign push_to_head = (count == 2'd0) | ((count == 2'd1) & pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetchPc    <= '0;
            count      <= '0;
            head_instr <= '0;
            head_pc    <= '0;
            tail_instr <= '0;
            tail_pc    <= '0;
        end else begin
            case (state)
                IDLE:    state <= RUN;
                RUN:     if (bus.haltReq & ~bus.branchTaken) state <= HALTED;
                HALTED:  if (~bus.haltReq) state <= RUN;
                default: state <= IDLE;
            endcase

            if (redirect) begin
                count   <= '0;
                fetchPc <= bus.branchTarget;
            end else begin
                count <= count + 2'(issue) - 2'(pop);
                if (issue)
                    fetchPc <= fetchPc + ADDR_WIDTH'(1);
                if (pop) begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                end
                if (issue) begin
                    if (push_to_head) begin
                        head_instr <= bus.memData;
                        head_pc    <= fetchPc;
                    end else begin
                        tail_instr <= bus.memData;
                        tail_pc    <= fetchPc;
                    end
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count_q;

    // Counts pushes only; a redirect leaves the running total alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fetch_count_q <= '0;
        else if (issue)
            fetch_count_q <= fetch_count_q + 16'd1;
    end

    assign bus.fetchCount = fetch_count_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: queue-based reference model compared every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_instruction_fetch;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(8)) ifc ();

    instruction_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.master)
    );

    always #5 clock = ~clock;

    // Instruction memory: read data settles on the falling edge of the address cycle.
    logic [7:0] mem [256];
    always @(negedge clock) ifc.memData <= mem[ifc.memAddress];

    // Reference model: a FIFO of {instr, pc}, a PC, and a run/halt phase.
    typedef struct packed {
        logic [7:0] ins;
        logic [7:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  mpc;
    int          mph;  // 0 = warm-up cycle, 1 = fetching, 2 = halted
    logic [15:0] mcnt;
    bit          m_pop;
    bit          m_iss;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            mpc  = 8'd0;
            mph  = 0;
            mcnt = 16'd0;
        end else if (mph == 0) begin
            mph = 1;
        end else begin
            m_pop = (mq.size() != 0) && ifc.instrReady;
            if (ifc.branchTaken) begin
                mq.delete();
                mpc = ifc.branchTarget;
                mph = (mph == 2 && ifc.haltReq) ? 2 : 1;
            end else begin
                m_iss = (mph == 1) && !ifc.haltReq && (mq.size() < 2 || m_pop);
                if (m_pop) void'(mq.pop_front());
                if (m_iss) begin
                    mq.push_back('{ins: mem[mpc], pc: mpc});
                    mpc  = mpc + 8'd1;
                    mcnt = mcnt + 16'd1;
                end
                mph = ifc.haltReq ? 2 : 1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            chk("model_valid", 16'(ifc.instrValid), 16'(mq.size() != 0));
            chk("model_addr", 16'(ifc.memAddress), 16'(mpc));
            if (mq.size() != 0) begin
                chk("model_pc", 16'(ifc.instrPc), 16'(mq[0].pc));
                chk("model_instr", 16'(ifc.instrOut), 16'(mq[0].ins));
            end
`ifdef FETCH_STATS_EN
            chk("model_fcnt", ifc.fetchCount, mcnt);
`endif
        end
    end

    task automatic step(input logic rdy, input logic br, input logic [7:0] tgt, input logic hlt);
        ifc.instrReady   = rdy;
        ifc.branchTaken  = br;
        ifc.branchTarget = tgt;
        ifc.haltReq      = hlt;
        @(negedge clock);
    endtask

    // Returns at a falling edge with reset released; the current cycle is cycle 0.
    task automatic do_reset(input logic [7:0] xmask);
        reset = 1'b1;
        ifc.instrReady   = 1'b0;
        ifc.branchTaken  = 1'b0;
        ifc.branchTarget = 8'd0;
        ifc.haltReq      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ xmask;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        // Straight-line fetch, mem[i] = i, decoder always ready.
        do_reset(8'h00);
        step(1, 0, 8'h00, 0);
        chk("a_c1_valid", 16'(ifc.instrValid), 16'd0);
        chk("a_c1_addr", 16'(ifc.memAddress), 16'd0);
        step(1, 0, 8'h00, 0);
        chk("a_c2_valid", 16'(ifc.instrValid), 16'd1);
        chk("a_c2_pc", 16'(ifc.instrPc), 16'd0);
        chk("a_c2_instr", 16'(ifc.instrOut), 16'd0);
        step(1, 0, 8'h00, 0);
        chk("a_c3_pc", 16'(ifc.instrPc), 16'd1);
        repeat (2) step(1, 0, 8'h00, 0);
        chk("a_c5_pc", 16'(ifc.instrPc), 16'd3);
        chk("a_c5_instr", 16'(ifc.instrOut), 16'd3);
`ifdef FETCH_STATS_EN
        chk("a_c5_fcnt", ifc.fetchCount, 16'd4);
`endif
        repeat (4) step(1, 0, 8'h00, 0);

        // Backpressure from cycle 1, then release.
        do_reset(8'hC3);
        repeat (4) step(0, 0, 8'h00, 0);
        chk("b_c4_addr", 16'(ifc.memAddress), 16'd2);
        chk("b_c4_pc", 16'(ifc.instrPc), 16'd0);
        step(1, 0, 8'h00, 0);
        chk("b_c5_pc", 16'(ifc.instrPc), 16'd1);
        step(1, 0, 8'h00, 0);
        chk("b_c6_pc", 16'(ifc.instrPc), 16'd2);
        step(1, 0, 8'h00, 0);
        chk("b_c7_pc", 16'(ifc.instrPc), 16'd3);
        chk("b_c7_instr", 16'(ifc.instrOut), 16'hC0);

        // Branch to 0x40 in cycle 5 with the buffer full.
        do_reset(8'hC3);
        repeat (5) step(0, 0, 8'h00, 0);
        chk("c_c5_valid", 16'(ifc.instrValid), 16'd1);
        step(0, 1, 8'h40, 0);
        chk("c_c6_valid", 16'(ifc.instrValid), 16'd0);
        chk("c_c6_addr", 16'(ifc.memAddress), 16'h40);
        step(1, 0, 8'h00, 0);
        chk("c_c7_pc", 16'(ifc.instrPc), 16'h40);
        chk("c_c7_instr", 16'(ifc.instrOut), 16'h83);
        step(1, 0, 8'h00, 0);
        chk("c_c8_pc", 16'(ifc.instrPc), 16'h41);

        // PC wrap across 0xFF.
        step(1, 1, 8'hFE, 0);
        chk("d_bubble", 16'(ifc.instrValid), 16'd0);
        step(1, 0, 8'h00, 0);
        chk("d_pc_fe", 16'(ifc.instrPc), 16'hFE);
        step(1, 0, 8'h00, 0);
        chk("d_pc_ff", 16'(ifc.instrPc), 16'hFF);
        step(1, 0, 8'h00, 0);
        chk("d_pc_00", 16'(ifc.instrPc), 16'h00);
        chk("d_instr_00", 16'(ifc.instrOut), 16'hC3);
        step(1, 0, 8'h00, 0);
        chk("d_pc_01", 16'(ifc.instrPc), 16'h01);

        // Halt for 4 cycles, resume sequentially; then branch while halted.
        step(1, 1, 8'h10, 0);
        repeat (3) step(1, 0, 8'h00, 0);
        chk("e_pre_halt_pc", 16'(ifc.instrPc), 16'h12);
        repeat (4) step(1, 0, 8'h00, 1);
        chk("e_halt_valid", 16'(ifc.instrValid), 16'd0);
        chk("e_halt_addr", 16'(ifc.memAddress), 16'h13);
        step(1, 0, 8'h00, 0);
        chk("e_resume_gap", 16'(ifc.instrValid), 16'd0);
        step(1, 0, 8'h00, 0);
        chk("e_resume_pc", 16'(ifc.instrPc), 16'h13);
        step(1, 0, 8'h00, 1);
        step(1, 1, 8'h80, 1);
        chk("e_hbr_addr", 16'(ifc.memAddress), 16'h80);
        chk("e_hbr_valid", 16'(ifc.instrValid), 16'd0);
        repeat (2) step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk("e_target_pc", 16'(ifc.instrPc), 16'h80);
        step(1, 0, 8'h00, 0);

        // Asynchronous reset with the buffer full.
        do_reset(8'h00);
        repeat (4) step(0, 0, 8'h00, 0);
        chk("f_full_valid", 16'(ifc.instrValid), 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("f_rst_valid", 16'(ifc.instrValid), 16'd0);
        chk("f_rst_addr", 16'(ifc.memAddress), 16'd0);
        chk("f_rst_pc", 16'(ifc.instrPc), 16'd0);
        chk("f_rst_instr", 16'(ifc.instrOut), 16'd0);
`ifdef FETCH_STATS_EN
        chk("f_rst_fcnt", ifc.fetchCount, 16'd0);
`endif
        do_reset(8'h00);
        repeat (2) step(1, 0, 8'h00, 0);
        chk("f_restart_pc", 16'(ifc.instrPc), 16'd0);
        step(1, 0, 8'h00, 0);
        chk("f_restart_pc1", 16'(ifc.instrPc), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
